// File: rtl/ipm_frame_sched.sv
// ipm_frame_sched: frame-pass scheduler in front of imag_transform and the framebuffer write port.
// Latency: start -> first coordinate 1 cycle; coordinate -> write strobe XF_LATENCY+1 cycles.
// Backpressure: i_stall holds the raster sweep only; results already in flight are still written.
//
// On i_start (IDLE only) the block latches i_mode onto o_im_p. It then issues every (line, pixel)
// of a FRAME_H x FRAME_W frame in raster order on o_line/o_pixel/o_valid. A valid bit travels
// XF_LATENCY stages alongside each coordinate. When the bit emerges, the transformed coordinate
// on i_xf_line/i_xf_pixel is registered onto o_wr_line/o_wr_pixel with o_wr_en one cycle later.
// o_done pulses once after the last write; o_busy is high from the first issue through o_done.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   i_start, i_mode, i_stall      frame start, transform mode (latched at start), issue hold-off
//   i_xf_line, i_xf_pixel         transformed coordinate returned by imag_transform
//   o_line, o_pixel, o_valid      coordinate to imag_transform, o_im_p latched mode
//   o_wr_en, o_wr_line, o_wr_pixel framebuffer write strobe and address
//   o_busy, o_done, o_clip_cnt    status, end-of-frame pulse, suppressed-result count
//
// Optional feature: define IPM_SCHED_CLIP_EN to suppress writes whose transformed coordinate
// falls outside the frame and count them in o_clip_cnt (saturating). Left undefined, every result
// is written and o_clip_cnt reads 0.
module ipm_frame_sched #(
  parameter int CAM_LINE   = 9,
  parameter int CAM_PIXEL  = 10,
  parameter int FRAME_H    = 480,
  parameter int FRAME_W    = 640,
  parameter int XF_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_start,
  input  logic [1:0]                    i_mode,
  input  logic                          i_stall,
  input  logic [CAM_LINE-1:0]           i_xf_line,
  input  logic [CAM_PIXEL-1:0]          i_xf_pixel,
  output logic [CAM_LINE-1:0]           o_line,
  output logic [CAM_PIXEL-1:0]          o_pixel,
  output logic                          o_valid,
  output logic [1:0]                    o_im_p,
  output logic                          o_wr_en,
  output logic [CAM_LINE-1:0]           o_wr_line,
  output logic [CAM_PIXEL-1:0]          o_wr_pixel,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [CAM_LINE+CAM_PIXEL-1:0] o_clip_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CAM_LINE-1:0]  LINE_LAST = CAM_LINE'(FRAME_H - 1);
  localparam logic [CAM_PIXEL-1:0] PIX_LAST  = CAM_PIXEL'(FRAME_W - 1);

  state_t                  state, state_nxt;
  logic [CAM_LINE-1:0]     line_cnt;
  logic [CAM_PIXEL-1:0]    pix_cnt;
  logic [XF_LATENCY-1:0]   vpipe;
  logic                    issue;
  logic                    last_coord;
  logic                    clip_hit;

  // The start cycle itself issues (0,0) so the first coordinate appears one cycle after i_start.
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    last_coord = (line_cnt == LINE_LAST) && (pix_cnt == PIX_LAST);
    case (state)
      IDLE: begin
        if (i_start) begin
          issue     = !i_stall;
          state_nxt = (issue && last_coord) ? DRAIN : RUN;
        end
      end
      RUN: begin
        issue = !i_stall;
        if (issue && last_coord) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Once nothing is on o_valid or in the valid pipe, the write currently in the output
        // stage (if any) is the last one, so o_done lands the cycle right after it.
        if (!o_valid && (vpipe == '0)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      line_cnt   <= '0;
      pix_cnt    <= '0;
      vpipe      <= '0;
      o_line     <= '0;
      o_pixel    <= '0;
      o_valid    <= 1'b0;
      o_im_p     <= '0;
      o_wr_en    <= 1'b0;
      o_wr_line  <= '0;
      o_wr_pixel <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_busy  <= (state_nxt != IDLE);
      o_done  <= (state_nxt == DONE);
      o_valid <= issue;

      if (state == IDLE && i_start) o_im_p <= i_mode;

      // Raster counters: advance only on an issue, held at (0,0) while idle.
      if (issue) begin
        o_line  <= line_cnt;
        o_pixel <= pix_cnt;
        if (pix_cnt == PIX_LAST) begin
          pix_cnt  <= '0;
          line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end else if (state == IDLE) begin
        line_cnt <= '0;
        pix_cnt  <= '0;
      end

      // Valid tracking matches the transform's fixed latency.
      vpipe[0] <= o_valid;
      for (int i = 1; i < XF_LATENCY; i++) vpipe[i] <= vpipe[i-1];

      o_wr_en <= vpipe[XF_LATENCY-1] && !clip_hit;
      if (vpipe[XF_LATENCY-1]) begin
        o_wr_line  <= i_xf_line;
        o_wr_pixel <= i_xf_pixel;
      end
    end
  end

`ifdef IPM_SCHED_CLIP_EN
  localparam int LW = CAM_LINE + 1;
  localparam int PW = CAM_PIXEL + 1;
  localparam logic [CAM_LINE:0]  LINE_LIM = LW'(FRAME_H);
  localparam logic [CAM_PIXEL:0] PIX_LIM  = PW'(FRAME_W);

  logic [CAM_LINE+CAM_PIXEL-1:0] clip_cnt;

  // One extra bit on each side so a frame dimension of exactly 2^width still compares correctly.
  assign clip_hit = ({1'b0, i_xf_line} >= LINE_LIM) || ({1'b0, i_xf_pixel} >= PIX_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      clip_cnt <= '0;
    end else if (state == IDLE && i_start) begin
      clip_cnt <= '0;
    end else if (vpipe[XF_LATENCY-1] && clip_hit && (clip_cnt != '1)) begin
      clip_cnt <= clip_cnt + 1'b1;
    end
  end

  assign o_clip_cnt = clip_cnt;
`else
  assign clip_hit   = 1'b0;
  assign o_clip_cnt = '0;
`endif

endmodule

// File: tb/tb_ipm_frame_sched.sv
`timescale 1ns/1ps
module tb_ipm_frame_sched;
  localparam int CL = 9;
  localparam int CP = 10;
  localparam int FH = 4;
  localparam int FW = 5;
  localparam int XL = 2;
  localparam int TOTAL = FH * FW;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic [1:0]    i_mode = 2'b00;
  logic          i_stall = 1'b0;
  logic [CL-1:0] i_xf_line;
  logic [CP-1:0] i_xf_pixel;
  logic [CL-1:0] o_line;
  logic [CP-1:0] o_pixel;
  logic          o_valid;
  logic [1:0]    o_im_p;
  logic          o_wr_en;
  logic [CL-1:0] o_wr_line;
  logic [CP-1:0] o_wr_pixel;
  logic          o_busy;
  logic          o_done;
  logic [CL+CP-1:0] o_clip_cnt;

  always #5 clk = ~clk;

  ipm_frame_sched #(
    .CAM_LINE(CL), .CAM_PIXEL(CP), .FRAME_H(FH), .FRAME_W(FW), .XF_LATENCY(XL)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_mode(i_mode), .i_stall(i_stall),
    .i_xf_line(i_xf_line), .i_xf_pixel(i_xf_pixel),
    .o_line(o_line), .o_pixel(o_pixel), .o_valid(o_valid), .o_im_p(o_im_p),
    .o_wr_en(o_wr_en), .o_wr_line(o_wr_line), .o_wr_pixel(o_wr_pixel),
    .o_busy(o_busy), .o_done(o_done), .o_clip_cnt(o_clip_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transform stand-in: two-cycle delay, identity unless clip_mode remaps line 2 to 7.
  logic clip_mode = 1'b0;

  function automatic logic [CL-1:0] xf_line_f(input logic [CL-1:0] l);
    return (clip_mode && l == 9'd2) ? 9'd7 : l;
  endfunction

  logic [CL-1:0] d1_l = '0, d2_l = '0;
  logic [CP-1:0] d1_p = '0, d2_p = '0;
  always @(posedge clk) begin
    d1_l <= xf_line_f(o_line);
    d1_p <= o_pixel;
    d2_l <= d1_l;
    d2_p <= d1_p;
  end
  assign i_xf_line  = d2_l;
  assign i_xf_pixel = d2_p;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: expectations per absolute cycle.
  bit iv[MAXC];
  int il[MAXC], ip[MAXC];
  bit ws[MAXC];
  int wl[MAXC], wp[MAXC];
  bit m_run = 1'b0;
  int m_start_c = -1, m_done_c = -1, m_n = 0, m_imp = 0, m_clip = 0;
  int armed_c = MAXC;

  int obs_first_valid = -1, obs_done_c = -1, obs_writes = 0, obs_dones = 0, obs_valids = 0;

  always @(negedge clk) begin : cmp
    int c;
    bit clipped;
    bit ewr;
    bit idle_now;
    c = cyc;
    if (c >= armed_c && c < MAXC - 16) begin
      clipped = 1'b0;
`ifdef IPM_SCHED_CLIP_EN
      clipped = ws[c] && (wl[c] >= FH || wp[c] >= FW);
      if (clipped && m_clip < (1 << (CL + CP)) - 1) m_clip++;
`endif
      ewr = ws[c] && !clipped;
      check("valid", int'(o_valid), int'(iv[c]));
      if (iv[c]) begin
        check("line", int'(o_line), il[c]);
        check("pixel", int'(o_pixel), ip[c]);
      end
      check("wr_en", int'(o_wr_en), int'(ewr));
      if (ewr) begin
        check("wr_line", int'(o_wr_line), wl[c]);
        check("wr_pixel", int'(o_wr_pixel), wp[c]);
      end
      check("done", int'(o_done), int'(m_run && c == m_done_c));
      check("busy", int'(o_busy), int'(m_run && c > m_start_c && (m_done_c < 0 || c <= m_done_c)));
      check("im_p", int'(o_im_p), m_imp);
      check("clip_cnt", int'(o_clip_cnt), m_clip);
      if (o_valid) begin
        obs_valids++;
        if (obs_first_valid < 0) obs_first_valid = c;
      end
      if (o_wr_en) obs_writes++;
      if (o_done) begin
        obs_dones++;
        obs_done_c = c;
      end
    end
    // Advance the model with the inputs the DUT samples at the next edge.
    if (reset) begin
      if (armed_c > c + 1) armed_c = c + 1;
      m_run = 1'b0; m_imp = 0; m_clip = 0; m_done_c = -1;
      for (int i = c + 1; i < c + 9 && i < MAXC; i++) begin
        iv[i] = 1'b0; ws[i] = 1'b0;
      end
    end else begin
      idle_now = !m_run || (m_done_c >= 0 && c > m_done_c);
      if (idle_now && i_start) begin
        m_run = 1'b1; m_start_c = c; m_n = 0; m_done_c = -1;
        m_imp = int'(i_mode); m_clip = 0;
        obs_first_valid = -1; obs_done_c = -1; obs_writes = 0; obs_dones = 0; obs_valids = 0;
      end
      if (m_run && m_done_c < 0 && m_n < TOTAL && !i_stall && c + 8 < MAXC) begin
        iv[c+1] = 1'b1;
        il[c+1] = m_n / FW;
        ip[c+1] = m_n % FW;
        ws[c+2+XL] = 1'b1;
        wl[c+2+XL] = int'(xf_line_f(CL'(m_n / FW)));
        wp[c+2+XL] = m_n % FW;
        m_n++;
        if (m_n == TOTAL) m_done_c = c + 1 + XL + 2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame from the current cycle s; k counts cycles after s.
  task automatic run_frame(input int stall_from, input int stall_len, input int retrig_k,
                           input int reset_k, output int s);
    s = cyc;
    i_start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (reset_k > 0 && k == reset_k + 1) begin
        check("rst_valid", int'(o_valid), 0);
        check("rst_wr_en", int'(o_wr_en), 0);
        check("rst_busy", int'(o_busy), 0);
      end
      i_start = (k == retrig_k);
      if (k == retrig_k) i_mode = 2'b10;
      i_stall = (k >= stall_from && k < stall_from + stall_len);
      reset = (k == reset_k);
      if (obs_done_c >= 0 && cyc > obs_done_c + 2) break;
    end
    i_start = 1'b0;
    i_stall = 1'b0;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s;
    repeat (3) tick();
    check("reset_valid", int'(o_valid), 0);
    check("reset_wr_en", int'(o_wr_en), 0);
    check("reset_busy", int'(o_busy), 0);
    check("reset_done", int'(o_done), 0);
    check("reset_im_p", int'(o_im_p), 0);
    check("reset_line", int'(o_line), 0);
    check("reset_pixel", int'(o_pixel), 0);
    check("reset_wr_line", int'(o_wr_line), 0);
    check("reset_wr_pixel", int'(o_wr_pixel), 0);
    check("reset_clip", int'(o_clip_cnt), 0);
    reset = 1'b0;
    repeat (5) tick();

    // Plain frame.
    run_frame(0, 0, 0, 0, s);
    check("plain_first_valid", obs_first_valid - s, 1);
    check("plain_done_cycle", obs_done_c - s, 24);
    check("plain_writes", obs_writes, 20);
    check("plain_valids", obs_valids, 20);
    check("plain_dones", obs_dones, 1);
    repeat (3) tick();

    // Three stall cycles while (1,2) is next.
    run_frame(7, 3, 0, 0, s);
    check("stall_done_cycle", obs_done_c - s, 27);
    check("stall_writes", obs_writes, 20);
    check("stall_valids", obs_valids, 20);
    repeat (3) tick();

    // Line 2 remapped out of frame.
    clip_mode = 1'b1;
    run_frame(0, 0, 0, 0, s);
    check("clip_done_cycle", obs_done_c - s, 24);
`ifdef IPM_SCHED_CLIP_EN
    check("clip_writes", obs_writes, 15);
    check("clip_count", int'(o_clip_cnt), 5);
`else
    check("clip_writes", obs_writes, 20);
    check("clip_count", int'(o_clip_cnt), 0);
`endif
    repeat (3) tick();
    clip_mode = 1'b0;
    repeat (3) tick();

    // Mode latched at start; mode change and second start mid-frame ignored.
    i_mode = 2'b01;
    run_frame(0, 0, 5, 0, s);
    check("mode_im_p", int'(o_im_p), 1);
    check("mode_done_cycle", obs_done_c - s, 24);
    repeat (20) tick();
    check("mode_dones", obs_dones, 1);
    check("mode_busy_after", int'(o_busy), 0);
    i_mode = 2'b00;

    // Reset mid-frame, then a fresh frame.
    run_frame(0, 0, 0, 10, s);
    check("rst_dones", obs_dones, 0);
    check("rst_writes", obs_writes, 7);
    repeat (3) tick();
    run_frame(0, 0, 0, 0, s);
    check("after_rst_writes", obs_writes, 20);
    check("after_rst_dones", obs_dones, 1);
    check("after_rst_done_cycle", obs_done_c - s, 24);

    // Randomized stall/start/mode/occasional reset, checked by the model every cycle.
    clip_mode = 1'b1;
    for (int k = 0; k < 700; k++) begin
      i_stall = ($urandom % 4) == 0;
      i_start = ($urandom % 12) == 0;
      i_mode  = 2'($urandom);
      reset   = ($urandom % 250) == 0;
      tick();
    end
    i_stall = 1'b0;
    i_start = 1'b0;
    reset = 1'b0;
    repeat (80) tick();
    check("final_idle", int'(o_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
